// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory / MMIO block: address map,
// TXSTAT bit positions, default sizes and the address decoder.
package dmem_mmio_pkg;

  localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;
  localparam int unsigned DEFAULT_FIFO_DEPTH  = 8;

  localparam logic [31:0] TXDATA_ADDR = 32'h8000_0000;
  localparam logic [31:0] TXSTAT_ADDR = 32'h8000_0004;
  localparam logic [31:0] CYCLO_ADDR  = 32'h8000_0008;
  localparam logic [31:0] CYCHI_ADDR  = 32'h8000_000C;

  localparam int unsigned TXSTAT_EMPTY_BIT    = 0;
  localparam int unsigned TXSTAT_FULL_BIT     = 1;
  localparam int unsigned TXSTAT_OVERFLOW_BIT = 2;

  typedef enum logic [2:0] {
    RGN_UNMAPPED,
    RGN_RAM,
    RGN_TXDATA,
    RGN_TXSTAT,
    RGN_CYCLO,
    RGN_CYCHI
  } region_e;

  // Word-granular decode; the two low address bits never take part.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [32:0] ram_bytes);
    region_e rgn;
    rgn = RGN_UNMAPPED;
    if ({1'b0, addr} < ram_bytes)              rgn = RGN_RAM;
    else if (addr[31:2] == TXDATA_ADDR[31:2])  rgn = RGN_TXDATA;
    else if (addr[31:2] == TXSTAT_ADDR[31:2])  rgn = RGN_TXSTAT;
    else if (addr[31:2] == CYCLO_ADDR[31:2])   rgn = RGN_CYCLO;
    else if (addr[31:2] == CYCHI_ADDR[31:2])   rgn = RGN_CYCHI;
    return rgn;
  endfunction

endpackage

// File: rtl/dmem_mmio_if.sv
// CPU data port plus TX byte stream, bundled for the dmem_mmio block.
interface dmem_mmio_if;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  // CPU + TX consumer side
  modport master (
    output daddr, dwdata, dwe, tx_ready,
    input  drdata, tx_data, tx_valid
  );

  // Memory / MMIO side
  modport slave (
    input  daddr, dwdata, dwe, tx_ready,
    output drdata, tx_data, tx_valid
  );
endinterface

// File: rtl/dmem_mmio_tx_fifo.sv
// TX byte FIFO with a sticky overflow flag. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; otherwise the byte
// is dropped and overflow is set (set beats a same-cycle clear).
module tx_fifo
  import dmem_mmio_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_i,
  input  logic [7:0]                    push_data_i,
  input  logic                          pop_i,
  input  logic                          ovf_clr_i,
  output logic [7:0]                    head_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          overflow_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          pop_ok, push_ok, drop;

  assign full_o     = (count_q == CW'(FIFO_DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign overflow_o = ovf_q;
  assign head_o     = empty_o ? '0 : fifo_mem_q[rd_ptr_q];

  // Next-state for pointers, occupancy and overflow flag
  always_comb begin
    pop_ok   = pop_i && !empty_o;
    push_ok  = push_i && (!full_o || pop_ok);
    drop     = push_i && full_o && !pop_ok;
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    ovf_d    = ovf_q;
    if (drop)           ovf_d = 1'b1;
    else if (ovf_clr_i) ovf_d = 1'b0;
  end

  // Control state register, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Byte storage; a push during reset is discarded
  always_ff @(posedge clk) begin
    if (push_ok && !reset) fifo_mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data RAM with memory-mapped TX FIFO and free-running 64-bit cycle counter.
// Reads are combinational; writes and all state updates occur on clk.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
  input logic        clk,
  input logic        reset,
  dmem_mmio_if.slave bus
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [63:0]   cyc_q, cyc_d;
  region_e       rgn;
  logic [AW-1:0] word_idx;

  logic          fifo_push, fifo_pop, fifo_clr;
  logic          fifo_full, fifo_empty, fifo_ovf;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;

  assign rgn      = decode_region(bus.daddr, RAM_BYTES);
  assign word_idx = bus.daddr[AW+1:2];

  assign fifo_push = (rgn == RGN_TXDATA) && bus.dwe[0];
  assign fifo_clr  = (rgn == RGN_TXSTAT) && bus.dwe[0] && bus.dwdata[TXSTAT_OVERFLOW_BIT];
  assign fifo_pop  = bus.tx_valid && bus.tx_ready;

  assign bus.tx_valid = (fifo_count != '0);
  assign bus.tx_data  = fifo_head;

  tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i (bus.dwdata[7:0]),
    .pop_i       (fifo_pop),
    .ovf_clr_i   (fifo_clr),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .overflow_o  (fifo_ovf)
  );

  // Byte-lane RAM write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (rgn == RGN_RAM && bus.dwe[i]) mem_q[word_idx][8*i +: 8] <= bus.dwdata[8*i +: 8];
    end
  end

  // Cycle counter next value
  always_comb begin
    cyc_d = cyc_q + 64'd1;
  end

  // Cycle counter register
  always_ff @(posedge clk) begin
    if (reset) cyc_q <= '0;
    else       cyc_q <= cyc_d;
  end

  // Read mux, zero-latency from address and current state
  always_comb begin
    bus.drdata = '0;
    unique case (rgn)
      RGN_RAM:    bus.drdata = mem_q[word_idx];
      RGN_TXSTAT: begin
        bus.drdata[TXSTAT_EMPTY_BIT]    = fifo_empty;
        bus.drdata[TXSTAT_FULL_BIT]     = fifo_full;
        bus.drdata[TXSTAT_OVERFLOW_BIT] = fifo_ovf;
      end
      RGN_CYCLO:  bus.drdata = cyc_q[31:0];
      RGN_CYCHI:  bus.drdata = cyc_q[63:32];
      default:    bus.drdata = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_mmio.sv
module tb_dmem_mmio;
  localparam int unsigned DW = 64;
  localparam int unsigned FD = 8;
  localparam logic [31:0] A_TXDATA = 32'h8000_0000;
  localparam logic [31:0] A_TXSTAT = 32'h8000_0004;
  localparam logic [31:0] A_CYCLO  = 32'h8000_0008;
  localparam logic [31:0] A_CYCHI  = 32'h8000_000C;

  logic clk = 1'b0;
  logic reset = 1'b1;
  dmem_mmio_if bus();

  dmem_mmio #(.DEPTH_WORDS(DW), .FIFO_DEPTH(FD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0]     m_ram   [DW];
  logic [3:0]      m_known [DW];
  byte unsigned    m_q[$];
  bit              m_ovf;
  longint unsigned m_cyc;
  bit              m_ok = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 unmapped, 1 RAM, 2 TXDATA, 3 TXSTAT, 4 CYCLO, 5 CYCHI
  function automatic int rgn_of(input logic [31:0] a);
    logic [31:0] w;
    if (a < 32'(4 * DW)) return 1;
    w = {a[31:2], 2'b00};
    if (w == A_TXDATA) return 2;
    if (w == A_TXSTAT) return 3;
    if (w == A_CYCLO)  return 4;
    if (w == A_CYCHI)  return 5;
    return 0;
  endfunction

  // Compare outputs against the model, then advance the model to the next edge
  always @(negedge clk) begin
    logic [31:0] a, exp, mask;
    int r, idx;
    bit pop, push, full, clr;
    a = bus.daddr;
    r = rgn_of(a);
    idx = int'(a >> 2) % DW;
    if (m_ok) begin
      mask = '1;
      exp  = '0;
      case (r)
        1: begin
          exp = m_ram[idx];
          for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{m_known[idx][i]}};
        end
        3: exp = {29'b0, m_ovf, m_q.size() == FD, m_q.size() == 0};
        4: exp = m_cyc[31:0];
        5: exp = m_cyc[63:32];
        default: exp = '0;
      endcase
      if (mask != '0) chk("drdata", bus.drdata & mask, exp & mask);
      chk("tx_valid", {31'b0, bus.tx_valid}, {31'b0, m_q.size() != 0});
      chk("tx_data", {24'b0, bus.tx_data}, {24'b0, (m_q.size() != 0) ? m_q[0] : 8'h00});
    end
    if (reset) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_cyc = 0;
      m_ok  = 1'b1;
    end else if (m_ok) begin
      full = (m_q.size() == FD);
      pop  = (m_q.size() != 0) && bus.tx_ready;
      push = (r == 2) && bus.dwe[0];
      clr  = (r == 3) && bus.dwe[0] && bus.dwdata[2];
      if (push && full && !pop) m_ovf = 1'b1;
      else if (clr)             m_ovf = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (push && (!full || pop)) m_q.push_back(bus.dwdata[7:0]);
      m_cyc++;
    end
    if (r == 1) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.dwe[i]) begin
          m_ram[idx][8*i +: 8] = bus.dwdata[8*i +: 8];
          m_known[idx][i] = 1'b1;
        end
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                       input logic rdy, input logic rst = 1'b0);
    @(posedge clk);
    #1;
    bus.daddr    = a;
    bus.dwdata   = d;
    bus.dwe      = we;
    bus.tx_ready = rdy;
    reset        = rst;
    #1;
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  we;
    int sel;
    for (int i = 0; i < DW; i++) m_known[i] = '0;
    bus.daddr = '0; bus.dwdata = '0; bus.dwe = '0; bus.tx_ready = 1'b0;

    drive(0, 0, 4'h0, 1'b0, 1'b1);
    drive(0, 0, 4'h0, 1'b0, 1'b1);

    // Reset state and cycle counter numbering
    drive(A_CYCLO, 0, 4'h0, 1'b0);
    chk("rst_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
    chk("rst_tx_data", {24'b0, bus.tx_data}, 32'h0);
    chk("cyclo_c0", bus.drdata, 32'd0);
    drive(A_TXSTAT, 0, 4'h0, 1'b0);
    chk("rst_txstat", bus.drdata, 32'h1);
    drive(A_CYCLO, 32'hFFFF_FFFF, 4'hF, 1'b0);
    chk("cyclo_c2_wr", bus.drdata, 32'd2);
    drive(A_CYCLO, 0, 4'h0, 1'b0);
    chk("cyclo_c3", bus.drdata, 32'd3);
    drive(A_CYCHI, 32'h1234_5678, 4'hF, 1'b0);
    chk("cychi", bus.drdata, 32'd0);

    // RAM byte-lane write, read-before-write, low address bits ignored
    drive(32'h10, 32'hAABB_CCDD, 4'hF, 1'b0);
    drive(32'h10, 32'h0000_1100, 4'b0010, 1'b0);
    chk("ram_prewrite", bus.drdata, 32'hAABB_CCDD);
    drive(32'h13, 0, 4'h0, 1'b0);
    chk("ram_bytewr", bus.drdata, 32'hAABB_11DD);
    drive(32'(4 * DW), 0, 4'h0, 1'b0);
    chk("unmapped_ram_end", bus.drdata, 32'h0);
    drive(32'h8000_0010, 32'hFFFF_FFFF, 4'hF, 1'b0);
    chk("unmapped_mmio", bus.drdata, 32'h0);
    drive(32'h8000_0003, 32'h0000_0000, 4'h0, 1'b0);
    chk("txdata_read", bus.drdata, 32'h0);

    // TX ordering
    drive(A_TXDATA, 32'h41, 4'b0001, 1'b0);
    drive(A_TXDATA, 32'h42, 4'b0001, 1'b0);
    drive(A_TXDATA, 32'hFFFF_FF43, 4'b1111, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 4'h0, 1'b1);
      chk("tx_order_valid", {31'b0, bus.tx_valid}, 32'h1);
      chk("tx_order_data", {24'b0, bus.tx_data}, 32'h41 + 32'(k));
    end
    drive(0, 0, 4'h0, 1'b1);
    chk("tx_order_drain", {31'b0, bus.tx_valid}, 32'h0);

    // Overflow and clear
    for (int k = 0; k < 9; k++) drive(A_TXDATA, 32'h10 + 32'(k), 4'b0001, 1'b0);
    drive(A_TXSTAT, 0, 4'h0, 1'b0);
    chk("ovf_stat", bus.drdata, 32'h6);
    drive(A_TXSTAT | 32'h1, 32'h4, 4'b0001, 1'b0);
    chk("ovf_clr_cycle", bus.drdata, 32'h6);
    drive(A_TXSTAT, 0, 4'h0, 1'b0);
    chk("ovf_cleared", bus.drdata, 32'h2);

    // Push while full with a simultaneous pop
    drive(A_TXDATA, 32'h55, 4'b0001, 1'b1);
    chk("fullpop_head", {24'b0, bus.tx_data}, 32'h10);
    drive(A_TXSTAT, 0, 4'h0, 1'b0);
    chk("fullpop_stat", bus.drdata, 32'h2);
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 4'h0, 1'b1);
      if (k == 7) chk("fullpop_8th", {24'b0, bus.tx_data}, 32'h55);
      else        chk("fullpop_seq", {24'b0, bus.tx_data}, 32'h11 + 32'(k));
    end
    drive(0, 0, 4'h0, 1'b0);
    chk("fullpop_empty", {31'b0, bus.tx_valid}, 32'h0);

    // Reset mid-operation with a push in the reset cycle
    for (int k = 0; k < 5; k++) drive(A_TXDATA, 32'hA0 + 32'(k), 4'b0001, 1'b0);
    drive(A_TXDATA, 32'h99, 4'b0001, 1'b0, 1'b1);
    drive(A_CYCLO, 0, 4'h0, 1'b0);
    chk("midrst_valid", {31'b0, bus.tx_valid}, 32'h0);
    chk("midrst_cyclo", bus.drdata, 32'h0);
    drive(A_TXSTAT, 0, 4'h0, 1'b0);
    chk("midrst_stat", bus.drdata, 32'h1);
    drive(32'h10, 0, 4'h0, 1'b0);
    chk("ram_survives_rst", bus.drdata, 32'hAABB_11DD);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2, 3: a = 32'($urandom_range(0, 4 * DW - 1));
        4, 9:       a = A_TXDATA | 32'($urandom_range(0, 3));
        5:          a = A_TXSTAT | 32'($urandom_range(0, 3));
        6:          a = A_CYCLO  | 32'($urandom_range(0, 3));
        7:          a = A_CYCHI  | 32'($urandom_range(0, 3));
        default:    a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(4 * DW, 4 * DW + 64))
                                                    : 32'h8000_0010 + 32'($urandom_range(0, 255));
      endcase
      d  = $urandom;
      we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      drive(a, d, we, $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
    end
    drive(0, 0, 4'h0, 1'b0);
    drive(0, 0, 4'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the data RAM (power of two).
REQ-002 Parameter FIFO_DEPTH, default 8, number of entries in the TX byte FIFO (power of two, at least 2).
REQ-003 clk  input  1  clock, all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 daddr  input  32  byte address from the CPU data port.
REQ-006 dwdata  input  32  write data from the CPU, byte lane i is bits [8i+7:8i].
REQ-007 dwe  input  4  per-byte write enables from the CPU; 4'b0000 means a read or idle cycle.
REQ-008 drdata  output  32  read data returned to the CPU in the same cycle.
REQ-009 tx_data  output  8  head byte of the TX FIFO.
REQ-010 tx_valid  output  1  TX FIFO is non-empty.
REQ-011 tx_ready  input  1  consumer accepts tx_data on a cycle where tx_valid and tx_ready are both high.

Function
REQ-012 Address map:
- RAM: daddr < 4*DEPTH_WORDS.
- TXDATA: 0x8000_0000.
- TXSTAT: 0x8000_0004.
- CYCLO: 0x8000_0008.
- CYCHI: 0x8000_000C.
- All other addresses: unmapped.
REQ-013 Decode ignores daddr[1:0]; all accesses are word accesses with byte lanes selected by dwe.
REQ-014 drdata is combinational from daddr and current state, with zero-cycle latency.
REQ-015 RAM reads return the word at daddr[log2(DEPTH_WORDS)+1:2].
- On a same-address write cycle, the read returns the pre-write contents.
REQ-016 RAM write: on the clock edge, each lane i with dwe[i]=1 takes dwdata byte i; lanes with dwe[i]=0 are unchanged.
REQ-017 TXDATA reads return 0.
- A TXDATA write with dwe[0]=1 pushes dwdata[7:0].
- Other lanes are ignored.
REQ-018 TXSTAT reads return {29'b0, overflow, full, empty}.
- A TXSTAT write with dwe[0]=1 and dwdata[2]=1 clears overflow.
REQ-019 A push while full with no pop in the same cycle drops the byte and sets the sticky overflow bit.
REQ-020 A push while full with a pop in the same cycle is accepted; occupancy stays at FIFO_DEPTH.
REQ-021 A push while empty makes tx_valid high on the following cycle; there is no same-cycle bypass.
REQ-022 Pop occurs when tx_valid and tx_ready are both high; tx_data advances on the next cycle.
REQ-023 FIFO pointers wrap modulo FIFO_DEPTH.
- full = (count == FIFO_DEPTH); empty = (count == 0).
REQ-024 A 64-bit cycle counter increments every non-reset cycle and wraps from all-ones to 0.
- CYCLO returns bits [31:0], CYCHI returns bits [63:32] of the current value.
- The counter is read-only; writes to it are ignored.
REQ-025 Unmapped reads return 0; unmapped writes change no state.
REQ-026 If a clear of overflow and a new overflow occur in the same cycle, the set wins.

Reset
REQ-027 On reset:
- FIFO count and both pointers = 0.
- overflow = 0, cycle counter = 0.
- tx_valid = 0, tx_data = 0.
REQ-028 Reset asserted mid-operation discards queued FIFO bytes; a push in that cycle is ignored.
REQ-029 RAM contents are not reset.
- drdata for RAM addresses reflects the stored contents regardless of reset.

Structure
REQ-030 A shared package holds the address-map base constants, the TXSTAT bit indices and the default parameter values.
REQ-031 The TX FIFO is a separate sub-module named tx_fifo, with push/pop/full/empty/count ports and FIFO_DEPTH as its parameter.
REQ-032 RAM storage, address decode, the read multiplexer and the cycle counter stay in dmem_mmio.

Verification
REQ-033 RAM byte write: write 0xAABBCCDD to 0x10 with dwe=1111, then dwe=0010 with data 0x00001100 -> read of 0x10 returns 0xAABB11DD.
REQ-034 TX order: push 0x41, 0x42, 0x43 with tx_ready=0, then hold tx_ready=1 -> tx_data sequence is 41, 42, 43; tx_valid drops after the third accept.
REQ-035 TX overflow: push 9 bytes with tx_ready=0 -> TXSTAT reads 0x6; write 0x4 to TXSTAT -> TXSTAT reads 0x2.
REQ-036 Full with simultaneous pop: with 8 bytes queued, push 0x55 while tx_ready=1 -> no overflow; the eighth byte popped after that is 0x55.
REQ-037 Cycle counter: after reset is released, CYCLO reads N in cycle N; writes to CYCLO leave it unaffected.
REQ-038 Reset mid-operation: with 5 bytes queued, assert reset for 1 cycle -> tx_valid=0, TXSTAT=0x1, CYCLO=0 on the first cycle after reset.
